// File: rtl/counter_seq.sv
// Sequencer for the shared counter: runs it to a commanded target, dwells, repeats for the
// commanded loop count, and flags a timeout if the counter never reaches the target.
module counter_seq #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [WIDTH-1:0]   cmd_target,
  input  logic [DWELL_W-1:0] cmd_dwell,
  input  logic [3:0]         cmd_loops,
  input  logic               abort,
  output logic               cnt_control,
  input  logic [WIDTH-1:0]   cnt_result,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [3:0]         loop_cnt
);

  typedef enum logic [1:0] {StIdle, StRun, StDwell} state_e;

  localparam logic [WIDTH:0] RunMax = {1'b1, {WIDTH{1'b0}}};

  state_e             state_q, state_d;
  logic               cnt_control_q, cnt_control_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [3:0]         loop_cnt_q, loop_cnt_d;
  logic [WIDTH-1:0]   target_q, target_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [3:0]         loops_q, loops_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [WIDTH:0]     run_cnt_q, run_cnt_d;

  logic [WIDTH-1:0]   target_m1;
  logic [DWELL_W-1:0] dwell_load;
  logic [4:0]         loops_eff;
  logic [4:0]         loops_next;

  assign cmd_ready   = (state_q == StIdle);
  assign cnt_control = cnt_control_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign loop_cnt    = loop_cnt_q;

  // Stopping one count early lets the counter's final increment land exactly on the target.
  assign target_m1  = target_q - WIDTH'(1);
  assign dwell_load = (dwell_q == '0) ? '0 : dwell_q - DWELL_W'(1);
  assign loops_eff  = (loops_q == 4'd0) ? 5'd1 : {1'b0, loops_q};
  assign loops_next = {1'b0, loop_cnt_q} + 5'd1;

  always_comb begin
    state_d       = state_q;
    cnt_control_d = cnt_control_q;
    done_d        = 1'b0;
    err_d         = err_q;
    loop_cnt_d    = loop_cnt_q;
    target_d      = target_q;
    dwell_d       = dwell_q;
    loops_d       = loops_q;
    dwell_cnt_d   = dwell_cnt_q;
    run_cnt_d     = run_cnt_q;

    unique case (state_q)
      StIdle: begin
        cnt_control_d = 1'b0;
        if (cmd_valid) begin
          state_d       = StRun;
          cnt_control_d = 1'b1;
          target_d      = cmd_target;
          dwell_d       = cmd_dwell;
          loops_d       = cmd_loops;
          loop_cnt_d    = 4'd0;
          err_d         = 1'b0;
          run_cnt_d     = '0;
        end
      end
      StRun: begin
        if (abort) begin
          state_d       = StIdle;
          cnt_control_d = 1'b0;
        end else if (cnt_result == target_m1) begin
          state_d       = StDwell;
          cnt_control_d = 1'b0;
          dwell_cnt_d   = dwell_load;
        end else if (run_cnt_q == RunMax) begin
          // 2^WIDTH+1 cycles without a stop: the counter is not following cnt_control.
          state_d       = StIdle;
          cnt_control_d = 1'b0;
          err_d         = 1'b1;
        end else begin
          run_cnt_d = run_cnt_q + 1'b1;
        end
      end
      StDwell: begin
        if (abort) begin
          state_d       = StIdle;
          cnt_control_d = 1'b0;
        end else if (dwell_cnt_q == '0) begin
          loop_cnt_d = loops_next[3:0];
          if (loops_next < loops_eff) begin
            state_d       = StRun;
            cnt_control_d = 1'b1;
            run_cnt_d     = '0;
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end else begin
          dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
        end
      end
      default: begin
        state_d       = StIdle;
        cnt_control_d = 1'b0;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_control_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      loop_cnt_q    <= 4'd0;
      target_q      <= '0;
      dwell_q       <= '0;
      loops_q       <= 4'd0;
      dwell_cnt_q   <= '0;
      run_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      cnt_control_q <= cnt_control_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      loop_cnt_q    <= loop_cnt_d;
      target_q      <= target_d;
      dwell_q       <= dwell_d;
      loops_q       <= loops_d;
      dwell_cnt_q   <= dwell_cnt_d;
      run_cnt_q     <= run_cnt_d;
    end
  end

endmodule

// File: tb/tb_counter_seq.sv
// Bench for counter_seq: a behavioural 4-bit counter closes the loop; command outcomes are
// queued as expectations when driven and checked when the sequencer returns to idle.
module tb_counter_seq;

  typedef struct {
    logic [3:0] start;
    logic [3:0] target;
    logic [3:0] dwell;
    logic [3:0] loops;
    int         exp_run;
    int         exp_dwell;
    logic [3:0] exp_final;
    logic [3:0] exp_loops;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_target;
  logic [3:0] cmd_dwell;
  logic [3:0] cmd_loops;
  logic       abort;
  logic       cnt_control;
  logic [3:0] cnt_result;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] loop_cnt;

  logic       force_en;
  logic [3:0] force_val;
  logic       hold_mode;
  logic [3:0] ctr;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t sb[$];
  vec_t tbl[5];

  always #5 clk = ~clk;

  // Counter model; hold_mode makes it ignore cnt_control to provoke a timeout.
  always @(posedge clk) begin
    if (force_en) ctr <= force_val;
    else if (cnt_control && !hold_mode) ctr <= ctr + 4'd1;
  end
  assign cnt_result = ctr;

  counter_seq #(.WIDTH(4), .DWELL_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_target (cmd_target),
    .cmd_dwell  (cmd_dwell),
    .cmd_loops  (cmd_loops),
    .abort      (abort),
    .cnt_control(cnt_control),
    .cnt_result (cnt_result),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .loop_cnt   (loop_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge while idle; returns at the negedge after the accept edge.
  task automatic drive_cmd(input bit do_force, input vec_t v);
    if (do_force) begin
      force_en  = 1'b1;
      force_val = v.start;
    end
    cmd_valid  = 1'b1;
    cmd_target = v.target;
    cmd_dwell  = v.dwell;
    cmd_loops  = v.loops;
    sb.push_back(v);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    force_en  = 1'b0;
  endtask

  // Called at the negedge of the first RUN cycle; observes until the sequencer is idle.
  task automatic track(input string tag);
    vec_t e;
    int   run_c = 0;
    int   dw_c  = 0;
    int   dn    = 0;
    int   n     = 0;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    while (busy === 1'b1 && n < 600) begin
      if (cnt_control) run_c++;
      else dw_c++;
      if (done) dn++;
      n++;
      @(negedge clk);
    end
    check({tag, "_bound"}, (n < 600), 1);
    check({tag, "_run_cycles"}, run_c, e.exp_run);
    check({tag, "_dwell_cycles"}, dw_c, e.exp_dwell);
    check({tag, "_done_while_busy"}, dn, 0);
    check({tag, "_done"}, done, 1);
    check({tag, "_final_ctr"}, ctr, e.exp_final);
    check({tag, "_loop_cnt"}, loop_cnt, e.exp_loops);
    check({tag, "_err"}, err, 0);
    check({tag, "_ready"}, cmd_ready, 1);
  endtask

  initial begin
    vec_t       v;
    int         run_c;
    int         dn;
    logic [3:0] diff;

    // start, target, dwell, loops, exp RUN cycles, exp DWELL cycles, final ctr, loop_cnt
    tbl[0] = '{4'd3,  4'd7,  4'd2, 4'd1, 4,  2,  4'd7,  4'd1};
    tbl[1] = '{4'd14, 4'd2,  4'd0, 4'd1, 4,  1,  4'd2,  4'd1};
    tbl[2] = '{4'd5,  4'd5,  4'd1, 4'd3, 48, 3,  4'd5,  4'd3};
    tbl[3] = '{4'd0,  4'd0,  4'd3, 4'd0, 16, 3,  4'd0,  4'd1};
    tbl[4] = '{4'd9,  4'd10, 4'd5, 4'd2, 17, 10, 4'd10, 4'd2};

    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_target = 4'd0;
    cmd_dwell  = 4'd0;
    cmd_loops  = 4'd0;
    abort      = 1'b0;
    hold_mode  = 1'b0;
    force_en   = 1'b1;
    force_val  = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_control", cnt_control, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_loop_cnt", loop_cnt, 0);
    check("rst_ready", cmd_ready, 1);
    rst      = 1'b0;
    force_en = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      drive_cmd(1'b1, tbl[i]);
      track($sformatf("vec%0d", i));
    end

    // Timeout: counter frozen at 0, target 9 is never reached.
    hold_mode  = 1'b1;
    force_en   = 1'b1;
    force_val  = 4'd0;
    cmd_valid  = 1'b1;
    cmd_target = 4'd9;
    cmd_dwell  = 4'd0;
    cmd_loops  = 4'd1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    force_en  = 1'b0;
    run_c     = 0;
    dn        = 0;
    while (busy === 1'b1 && run_c < 100) begin
      if (cnt_control) run_c++;
      if (done) dn++;
      @(negedge clk);
    end
    check("to_run_cycles", run_c, 17);
    check("to_err", err, 1);
    check("to_control", cnt_control, 0);
    check("to_no_done", dn + int'(done), 0);
    check("to_ready", cmd_ready, 1);
    hold_mode = 1'b0;
    v = '{4'd0, 4'd3, 4'd0, 4'd1, 3, 1, 4'd3, 4'd1};
    drive_cmd(1'b1, v);
    check("to_err_cleared", err, 0);
    track("after_to");

    // Abort mid-run, then re-command on the very next cycle.
    force_en   = 1'b1;
    force_val  = 4'd0;
    cmd_valid  = 1'b1;
    cmd_target = 4'd10;
    cmd_dwell  = 4'd0;
    cmd_loops  = 4'd1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    force_en  = 1'b0;
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    check("ab_busy", busy, 0);
    check("ab_done", done, 0);
    check("ab_control", cnt_control, 0);
    check("ab_ctr", (ctr == 4'd4 || ctr == 4'd5), 1);
    diff = 4'd12 - ctr;
    v    = '{4'd0, 4'd12, 4'd0, 4'd1, int'(diff), 1, 4'd12, 4'd1};
    drive_cmd(1'b0, v);
    track("re_cmd");

    // Reset mid-DWELL with cmd_valid held high through reset.
    cmd_valid  = 1'b1;
    cmd_target = 4'd14;
    cmd_dwell  = 4'd6;
    cmd_loops  = 4'd1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_in_dwell", {busy, cnt_control}, 2'b10);
    rst        = 1'b1;
    cmd_valid  = 1'b1;
    cmd_target = 4'd1;
    cmd_dwell  = 4'd0;
    cmd_loops  = 4'd1;
    @(posedge clk);
    @(negedge clk);
    check("mrst_busy", busy, 0);
    check("mrst_control", cnt_control, 0);
    check("mrst_done", done, 0);
    check("mrst_loop_cnt", loop_cnt, 0);
    check("mrst_ready", cmd_ready, 1);
    check("mrst_ctr_held", ctr, 14);
    @(posedge clk);
    @(negedge clk);
    check("mrst_no_accept", busy, 0);
    rst = 1'b0;
    sb.push_back('{4'd14, 4'd1, 4'd0, 4'd1, 3, 1, 4'd1, 4'd1});
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("post_rst_accept", {busy, cnt_control}, 2'b11);
    track("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
